alu_mc: RTL

Parametrised multi-cycle ALU for the IDIOT datapath. It is the next generation of the single-cycle combinational ALU: the same seven base operations, plus subtract, shift-left, iterative multiply and variable logical shift-right. It has a start/busy/done handshake and a registered result. It sits between the stack-operand registers and the write-back path; the control FSM stalls on busy.

---
 rtl/alu_mc.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle base ops plus iterative shift-add multiply
// and a one-bit-per-cycle variable right shift, behind a start/busy/done handshake.
module alu_mc #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       ALUop,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] Z
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MUL   = 2'd1,
    S_SHIFT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] shval_q, shval_d;
  logic [SHW-1:0]   n_q, n_d;
  logic [WIDTH-1:0] z_q, z_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] single_res;
  logic             illegal_op;
  logic [WIDTH-1:0] acc_step;

  // Result of every op that completes in the accepting cycle
  always_comb begin
    single_res = '0;
    case (ALUop)
      4'd0:    single_res = X + Y;
      4'd1:    single_res = X & Y;
      4'd2:    single_res = X | Y;
      4'd3:    single_res = X ^ Y;
      4'd4:    single_res = {{(WIDTH-1){1'b0}}, |X};
      4'd5:    single_res = X >> 1;
      4'd6:    single_res = Y;
      4'd7:    single_res = X - Y;
      4'd8:    single_res = X << 1;
      default: single_res = '0;
    endcase
  end

  assign illegal_op = (ALUop > 4'd10);
  assign acc_step   = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      count_q  <= '0;
      shval_q  <= '0;
      n_q      <= '0;
      z_q      <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      shval_q  <= shval_d;
      n_q      <= n_d;
      z_q      <= z_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    count_d  = count_q;
    shval_d  = shval_q;
    n_d      = n_q;
    z_d      = z_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (ALUop == 4'd9) begin
            mcand_d  = X;
            mplier_d = Y;
            acc_d    = '0;
            count_d  = CW'(WIDTH);
            state_d  = S_MUL;
          end else if (ALUop == 4'd10) begin
            // A zero shift amount needs no iteration
            if (Y[SHW-1:0] == '0) begin
              z_d    = X;
              done_d = 1'b1;
            end else begin
              shval_d = X;
              n_d     = Y[SHW-1:0];
              state_d = S_SHIFT;
            end
          end else begin
            z_d    = single_res;
            err_d  = illegal_op;
            done_d = 1'b1;
          end
        end
      end
      S_MUL: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q - CW'(1);
        if (count_q == CW'(1)) begin
          z_d     = acc_step;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        shval_d = shval_q >> 1;
        n_d     = n_q - SHW'(1);
        if (n_q == SHW'(1)) begin
          z_d     = shval_q >> 1;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != S_IDLE);
  end

  assign done = done_q;
  assign err  = err_q;
  assign Z    = z_q;

endmodule
